// File: rtl/coax_pkg.sv
// Shared definitions for the buffered coax Manchester transmitter.
package coax_pkg;

   localparam int CPB_DEFAULT = 8;
   localparam int DW_DEFAULT  = 10;

   // Frame states in line order: quiesce, code violation, then per word sync/data/parity, then end.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LQ1, ST_LQ2, ST_LQ3, ST_LQ4, ST_LQ5, ST_LQ6,
      ST_CV1, ST_CV2, ST_CV3,
      ST_SYNC, ST_DATA, ST_PARITY,
      ST_END1, ST_END2, ST_END3
   } state_t;

   // Manchester symbol for one bit: complement in the first half, true value in the second.
   function automatic logic manchester(input logic first_half, input logic bit_value);
      return first_half ? ~bit_value : bit_value;
   endfunction

endpackage

// File: rtl/coax_tx_fifo.sv
// Word FIFO feeding the transmitter; push and pop may happen in the same clock.
module coax_tx_fifo
   import coax_pkg::*;
#(
   parameter int DATA_WIDTH = DW_DEFAULT,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; only occupied entries are ever read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data;
   end

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/coax_buffered_tx.sv
// Buffered coax transmitter: queues words and sends them as Manchester frames,
// chaining queued words back-to-back inside one frame.
//
// Input handshake: a word is accepted on a rising clk edge when data_valid and
// data_ready are both high; data_valid while data_ready is low has no effect.
module coax_buffered_tx
   import coax_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = CPB_DEFAULT,
   parameter int DATA_WIDTH     = DW_DEFAULT,
   parameter int DEPTH          = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic                  tx,
   output logic                  active,
   output logic                  tx_delay,
   output logic                  busy,
   output logic                  empty
);

   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_COUNT = CW'(CLOCKS_PER_BIT / 2);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

   state_t                state;
   logic [CW-1:0]         bit_count;
   logic [BW-1:0]         bit_index;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  parity;
   logic [1:0]            delay_stage;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  push;
   logic                  pop;
   logic                  strobe;
   logic                  first_half;

   assign strobe     = (bit_count == LAST_COUNT);
   assign first_half = (bit_count < HALF_COUNT);
   assign push       = data_valid && !fifo_full;
   assign pop        = strobe && ((state == ST_CV3) || ((state == ST_PARITY) && !fifo_empty));

   coax_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .data    (data),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

   // Frame sequencer with bit timer; every move except leaving IDLE waits for the bit strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         bit_count <= '0;
         bit_index <= '0;
         shift_reg <= '0;
         parity    <= 1'b0;
      end else if (state == ST_IDLE) begin
         bit_count <= '0;
         if (!fifo_empty) state <= ST_LQ1;
      end else begin
         bit_count <= strobe ? '0 : bit_count + CW'(1);
         if (strobe) begin
            case (state)
               ST_LQ1:  state <= ST_LQ2;
               ST_LQ2:  state <= ST_LQ3;
               ST_LQ3:  state <= ST_LQ4;
               ST_LQ4:  state <= ST_LQ5;
               ST_LQ5:  state <= ST_LQ6;
               ST_LQ6:  state <= ST_CV1;
               ST_CV1:  state <= ST_CV2;
               ST_CV2:  state <= ST_CV3;
               ST_CV3: begin
                  shift_reg <= fifo_head;
                  parity    <= 1'b1;
                  bit_index <= '0;
                  state     <= ST_SYNC;
               end
               ST_SYNC: state <= ST_DATA;
               ST_DATA: begin
                  shift_reg <= shift_reg << 1;
                  parity    <= parity ^ shift_reg[DATA_WIDTH-1];
                  if (bit_index == LAST_BIT) state <= ST_PARITY;
                  else                       bit_index <= bit_index + BW'(1);
               end
               ST_PARITY: begin
                  // A queued word continues the frame without another quiesce.
                  if (!fifo_empty) begin
                     shift_reg <= fifo_head;
                     parity    <= 1'b1;
                     bit_index <= '0;
                     state     <= ST_SYNC;
                  end else begin
                     state <= ST_END1;
                  end
               end
               ST_END1: state <= ST_END2;
               ST_END2: state <= ST_END3;
               ST_END3: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Line encoding decoded straight from the registered state and bit timer.
   always_comb begin
      tx = 1'b0;
      case (state)
         ST_LQ1, ST_LQ2, ST_LQ3,
         ST_LQ4, ST_LQ5, ST_LQ6: tx = manchester(first_half, 1'b1);
         ST_CV1:                 tx = 1'b0;
         ST_CV2:                 tx = manchester(first_half, 1'b1);
         ST_CV3:                 tx = 1'b1;
         ST_SYNC:                tx = manchester(first_half, 1'b1);
         ST_DATA:                tx = manchester(first_half, shift_reg[DATA_WIDTH-1]);
         ST_PARITY:              tx = manchester(first_half, parity);
         ST_END1:                tx = manchester(first_half, 1'b0);
         ST_END2, ST_END3:       tx = 1'b1;
         default:                tx = 1'b0;
      endcase
   end

   // Two-clock copy of the line, held at ones whenever the driver is off.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     delay_stage <= 2'b11;
      else if (!active) delay_stage <= 2'b11;
      else              delay_stage <= {delay_stage[0], tx};
   end

   assign busy       = (state != ST_IDLE);
   assign active     = ((state == ST_LQ1) && !first_half) ||
                       ((state != ST_IDLE) && (state != ST_LQ1));
   assign tx_delay   = active ? delay_stage[1] : 1'b0;
   assign data_ready = !fifo_full;
   assign empty      = fifo_empty;

endmodule

// File: tb/tb_coax_buffered_tx.sv
// Bench for coax_buffered_tx: frame-level line model, FIFO limits, reset and delay tap.
module tb_coax_buffered_tx;

   localparam int C  = 8;
   localparam int DW = 10;
   localparam int D  = 8;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] data = '0;
   logic          data_valid = 1'b0;

   always #5 clk = ~clk;

   logic data_ready, tx, active, tx_delay, busy, empty;
   logic data_ready_4, tx_4, active_4, tx_delay_4, busy_4, empty_4;
   logic data_ready_16, tx_16, active_16, tx_delay_16, busy_16, empty_16;

   coax_buffered_tx #(.CLOCKS_PER_BIT(C), .DATA_WIDTH(DW), .DEPTH(D)) dut (
      .clk(clk), .reset_n(reset_n), .data(data), .data_valid(data_valid),
      .data_ready(data_ready), .tx(tx), .active(active), .tx_delay(tx_delay),
      .busy(busy), .empty(empty));

   coax_buffered_tx #(.CLOCKS_PER_BIT(4), .DATA_WIDTH(DW), .DEPTH(D)) dut_4 (
      .clk(clk), .reset_n(reset_n), .data(data), .data_valid(data_valid),
      .data_ready(data_ready_4), .tx(tx_4), .active(active_4), .tx_delay(tx_delay_4),
      .busy(busy_4), .empty(empty_4));

   coax_buffered_tx #(.CLOCKS_PER_BIT(16), .DATA_WIDTH(DW), .DEPTH(D)) dut_16 (
      .clk(clk), .reset_n(reset_n), .data(data), .data_valid(data_valid),
      .data_ready(data_ready_16), .tx(tx_16), .active(active_16), .tx_delay(tx_delay_16),
      .busy(busy_16), .empty(empty_16));

   int n_cmp = 0;
   int n_bad = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- monitor: one {active,busy,tx} sample per clock ----------------
   logic [2:0] got_q[$];
   logic       dr_q[$];
   logic       mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         got_q.push_back({active, busy, tx});
         dr_q.push_back(data_ready);
      end
   end

   // ---------------- reference model: expected line samples ----------------
   logic [2:0]    exp_q[$];
   logic [DW-1:0] wq[$];

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
   endtask

   // One bit time: half a bit of h1 then half a bit of h2, busy throughout.
   task automatic add_sym(input logic h1, input logic h2, input logic act_first);
      for (int i = 0; i < C/2; i++) exp_q.push_back({act_first, 1'b1, h1});
      for (int i = 0; i < C/2; i++) exp_q.push_back({1'b1, 1'b1, h2});
   endtask

   // A frame carrying every word in wq, built from the line protocol description.
   task automatic build_frame();
      logic p;
      logic b;
      for (int i = 0; i < 6; i++) add_sym(1'b0, 1'b1, (i != 0));
      add_sym(1'b0, 1'b0, 1'b1);
      add_sym(1'b0, 1'b1, 1'b1);
      add_sym(1'b1, 1'b1, 1'b1);
      foreach (wq[k]) begin
         add_sym(1'b0, 1'b1, 1'b1);
         p = 1'b1;
         for (int i = DW-1; i >= 0; i--) begin
            b = wq[k][i];
            add_sym(~b, b, 1'b1);
            p = p ^ b;
         end
         add_sym(~p, p, 1'b1);
      end
      add_sym(1'b1, 1'b0, 1'b1);
      add_sym(1'b1, 1'b1, 1'b1);
      add_sym(1'b1, 1'b1, 1'b1);
   endtask

   function automatic int first_diff();
      int n;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic start_capture();
      @(posedge clk); #1;
      got_q.delete(); dr_q.delete(); exp_q.delete(); wq.delete();
      mon_en = 1'b1;
   endtask

   // Called just after a rising edge; the word is taken on the next edge.
   task automatic drive_word(input logic [DW-1:0] w);
      data = w;
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
   endtask

   task automatic collect_stream();
      int budget;
      budget = exp_q.size() + 200;
      while (got_q.size() < exp_q.size() && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      mon_en = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (tx !== 1'b0)         begin n_bad++; $display("FAIL reset_tx: got %b expected 0", tx); end
      n_cmp++; if (active !== 1'b0)     begin n_bad++; $display("FAIL reset_active: got %b expected 0", active); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (tx_delay !== 1'b0)   begin n_bad++; $display("FAIL reset_tx_delay: got %b expected 0", tx_delay); end
      n_cmp++; if (empty !== 1'b1)      begin n_bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
      n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL reset_data_ready: got %b expected 1", data_ready); end
      @(posedge clk); #2;
      reset_n = 1'b1;
   endtask

   task automatic test_single_word();
      int d;
      logic [DW-1:0] dec;
      logic par;
      start_capture();
      wq.push_back(10'b0000000101);
      add_idle(2); build_frame(); add_idle(2);
      drive_word(10'b0000000101);
      collect_stream();
      n_cmp++;
      if (got_q.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL single_length: got %0d samples expected %0d", got_q.size(), exp_q.size());
      end
      d = first_diff();
      n_cmp++;
      if (d >= 0) begin
         n_bad++; $display("FAIL single_stream: sample %0d got %b expected %b", d, got_q[d], exp_q[d]);
      end
      dec = '0; par = 1'b0;
      if (got_q.size() >= 2 + 24*C) begin
         for (int i = 0; i < DW; i++) dec[DW-1-i] = got_q[2 + (10+i)*C + C-1][0];
         par = got_q[2 + 20*C + C-1][0];
      end
      n_cmp++; if (dec !== 10'b0000000101) begin n_bad++; $display("FAIL single_decode: got %b expected 0000000101", dec); end
      n_cmp++; if (par !== 1'b1)           begin n_bad++; $display("FAIL single_parity: got %b expected 1", par); end
      n_cmp++; if (busy !== 1'b0 || empty !== 1'b1) begin
         n_bad++; $display("FAIL single_after: busy %b empty %b expected 0 1", busy, empty);
      end
   endtask

   task automatic test_back_to_back();
      int d;
      logic [DW-1:0] w;
      start_capture();
      for (int i = 0; i < 3; i++) wq.push_back(DW'($urandom));
      add_idle(2); build_frame(); add_idle(2);
      foreach (wq[i]) begin
         w = wq[i];
         drive_word(w);
      end
      collect_stream();
      d = first_diff();
      n_cmp++;
      if (got_q.size() !== exp_q.size() || d >= 0) begin
         n_bad++; $display("FAIL back_to_back_stream: size %0d/%0d first diff %0d", got_q.size(), exp_q.size(), d);
      end
      n_cmp++;
      if (exp_q.size() !== 4 + 48*C) begin
         n_bad++; $display("FAIL back_to_back_frame_len: got %0d expected %0d", exp_q.size(), 4 + 48*C);
      end
   endtask

   task automatic test_random_frames();
      int d, n;
      logic [DW-1:0] w;
      for (int it = 0; it < 3; it++) begin
         start_capture();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
         add_idle(2); build_frame(); add_idle(2);
         foreach (wq[i]) begin
            w = wq[i];
            drive_word(w);
         end
         collect_stream();
         d = first_diff();
         n_cmp++;
         if (got_q.size() !== exp_q.size() || d >= 0) begin
            n_bad++; $display("FAIL random_frame_%0d (%0d words): size %0d/%0d first diff %0d",
                              it, n, got_q.size(), exp_q.size(), d);
         end
      end
   endtask

   task automatic test_parity_boundary();
      int d;
      logic [DW-1:0] w1, w2;
      for (int late = 0; late < 2; late++) begin
         w1 = DW'($urandom); w2 = DW'($urandom);
         start_capture();
         add_idle(2);
         if (late == 0) begin
            wq.push_back(w1); wq.push_back(w2); build_frame();
         end else begin
            wq.push_back(w1); build_frame(); add_idle(1);
            wq.delete(); wq.push_back(w2); build_frame();
         end
         add_idle(2);
         drive_word(w1);
         repeat (21*C + late - 1) @(posedge clk);
         #1;
         drive_word(w2);
         collect_stream();
         d = first_diff();
         n_cmp++;
         if (got_q.size() !== exp_q.size() || d >= 0) begin
            n_bad++; $display("FAIL parity_boundary_%s: size %0d/%0d first diff %0d",
                              (late == 0) ? "on_strobe" : "late", got_q.size(), exp_q.size(), d);
         end
      end
   endtask

   task automatic test_fifo_full();
      int d;
      logic [DW-1:0] w;
      pulse_reset();
      start_capture();
      for (int i = 0; i < D; i++) wq.push_back(DW'($urandom));
      add_idle(2); build_frame(); add_idle(2);
      foreach (wq[i]) begin
         w = wq[i];
         drive_word(w);
      end
      drive_word(DW'($urandom));
      collect_stream();
      n_cmp++; if (dr_q.size() < 9*C + 3 || dr_q[7] !== 1'b1) begin
         n_bad++; $display("FAIL full_ready_before: got %b expected 1", (dr_q.size() > 7) ? dr_q[7] : 1'bx);
      end
      n_cmp++; if (dr_q.size() < 9*C + 3 || dr_q[8] !== 1'b0 || dr_q[9] !== 1'b0) begin
         n_bad++; $display("FAIL full_ready_low: samples 8,9 not both 0");
      end
      n_cmp++; if (dr_q.size() < 9*C + 3 || dr_q[9*C+1] !== 1'b0) begin
         n_bad++; $display("FAIL full_ready_before_pop: got %b expected 0", (dr_q.size() > 9*C+1) ? dr_q[9*C+1] : 1'bx);
      end
      n_cmp++; if (dr_q.size() < 9*C + 3 || dr_q[9*C+2] !== 1'b1) begin
         n_bad++; $display("FAIL full_ready_after_pop: got %b expected 1", (dr_q.size() > 9*C+2) ? dr_q[9*C+2] : 1'bx);
      end
      d = first_diff();
      n_cmp++;
      if (got_q.size() !== exp_q.size() || d >= 0) begin
         n_bad++; $display("FAIL full_stream_drop: size %0d/%0d first diff %0d", got_q.size(), exp_q.size(), d);
      end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL full_empty_after: got %b expected 1", empty); end
   endtask

   task automatic test_tx_delay();
      logic [2:0] act_v, tx_v, td_v, seen;
      logic [1:0] h_act [3];
      logic [1:0] h_tx  [3];
      logic       e;
      pulse_reset();
      for (int j = 0; j < 3; j++) begin h_act[j] = 2'b00; h_tx[j] = 2'b00; end
      seen = '0;
      @(posedge clk); #1;
      drive_word(DW'($urandom));
      repeat (24*16 + 20) begin
         @(negedge clk);
         act_v = {active_16, active_4, active};
         tx_v  = {tx_16, tx_4, tx};
         td_v  = {tx_delay_16, tx_delay_4, tx_delay};
         for (int j = 0; j < 3; j++) begin
            // Two clocks back while the driver was already on; ones right after switch-on.
            e = act_v[j] ? ((h_act[j] == 2'b11) ? h_tx[j][1] : 1'b1) : 1'b0;
            n_cmp++;
            if (td_v[j] !== e) begin
               n_bad++; $display("FAIL tx_delay_inst%0d at %0t: got %b expected %b", j, $time, td_v[j], e);
            end
            seen[j] = seen[j] | act_v[j];
            h_act[j] = {h_act[j][0], act_v[j]};
            h_tx[j]  = {h_tx[j][0], tx_v[j]};
         end
      end
      n_cmp++; if (seen !== 3'b111) begin n_bad++; $display("FAIL tx_delay_activity: got %b expected 111", seen); end
   endtask

   task automatic test_reset_mid_frame();
      logic saw_busy;
      start_capture();
      mon_en = 1'b0;
      drive_word(DW'($urandom));
      drive_word(DW'($urandom));
      drive_word(DW'($urandom));
      repeat (12*C) @(posedge clk);
      #2;
      n_cmp++; if (active !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL midframe_pre: active %b busy %b expected 1 1", active, busy);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (tx !== 1'b0)       begin n_bad++; $display("FAIL midframe_tx: got %b expected 0", tx); end
      n_cmp++; if (active !== 1'b0)   begin n_bad++; $display("FAIL midframe_active: got %b expected 0", active); end
      n_cmp++; if (tx_delay !== 1'b0) begin n_bad++; $display("FAIL midframe_tx_delay: got %b expected 0", tx_delay); end
      n_cmp++; if ({empty, empty_4, empty_16} !== 3'b111) begin
         n_bad++; $display("FAIL midframe_empty: got %b expected 111", {empty, empty_4, empty_16});
      end
      n_cmp++; if ({busy, busy_4, busy_16} !== 3'b000 || data_ready !== 1'b1) begin
         n_bad++; $display("FAIL midframe_busy_ready: busy %b ready %b expected 000 1", {busy, busy_4, busy_16}, data_ready);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      saw_busy = 1'b0;
      repeat (30*C) begin
         @(negedge clk);
         saw_busy = saw_busy | busy | active | tx;
      end
      n_cmp++; if (saw_busy !== 1'b0) begin n_bad++; $display("FAIL midframe_no_restart: got activity %b expected 0", saw_busy); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_random_frames();
      test_parity_boundary();
      test_fifo_full();
      test_tx_delay();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
